// File: rtl/rv64_multiplier_if.sv
// Request/response bundle between the execute stage and the iterative RV64M multiplier.
interface rv64_multiplier_if #(
  parameter int XLEN = 64
);
  logic            mult_ready;
  logic [9:0]      inst_op_f3;
  logic [XLEN-1:0] mult_op1;
  logic [XLEN-1:0] mult_op2;
  logic [XLEN-1:0] product_val;
  logic            mult_finish;
  logic            busy_o;

  modport master (
    output mult_ready, inst_op_f3, mult_op1, mult_op2,
    input  product_val, mult_finish, busy_o
  );

  modport slave (
    input  mult_ready, inst_op_f3, mult_op1, mult_op2,
    output product_val, mult_finish, busy_o
  );
endinterface

// File: rtl/rv64_multiplier.sv
// Iterative radix-2 shift-add RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Optional MULT_ZERO_BYPASS_EN: a zero operand magnitude skips straight to DONE.
module rv64_multiplier #(
  parameter int XLEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  rv64_multiplier_if.slave   bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_D = CW'(XLEN - 1);
  localparam logic [CW-1:0] LAST_W = CW'(XLEN / 2 - 1);

  localparam logic [9:0] C_MUL    = 10'b0110011_000;
  localparam logic [9:0] C_MULH   = 10'b0110011_001;
  localparam logic [9:0] C_MULHSU = 10'b0110011_010;
  localparam logic [9:0] C_MULHU  = 10'b0110011_011;
  localparam logic [9:0] C_MULW   = 10'b0111011_000;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [2:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW} optype_t;

  state_t              r_state;
  optype_t             r_op;
  logic                r_sign;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_product;
  logic                r_finish;
  logic                r_busy;

  logic                w_valid;
  optype_t             w_op;
  logic                w_sgn1;
  logic                w_sgn2;
  logic [XLEN-1:0]     w_a1;
  logic [XLEN-1:0]     w_a2;
  logic                w_neg1;
  logic                w_neg2;
  logic [XLEN-1:0]     w_mag1;
  logic [XLEN-1:0]     w_mag2;
  logic [CW-1:0]       w_last;

  // Magnitude of a two's-complement value; -2^(XLEN-1) maps to 2^(XLEN-1) as unsigned.
  function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_neg(input logic [2*XLEN-1:0] p, input logic neg);
    return neg ? (~p + (2*XLEN)'(1)) : p;
  endfunction

  function automatic logic [XLEN-1:0] f_select(input optype_t op, input logic [2*XLEN-1:0] p);
    logic [XLEN-1:0] res;
    case (op)
      OP_MUL:  res = p[XLEN-1:0];
      OP_MULW: res = {{(XLEN/2){p[XLEN/2-1]}}, p[XLEN/2-1:0]};
      default: res = p[2*XLEN-1:XLEN];
    endcase
    return res;
  endfunction

  always_comb begin
    w_valid = 1'b1;
    w_op    = OP_MUL;
    w_sgn1  = 1'b1;
    w_sgn2  = 1'b1;
    case (bus.inst_op_f3)
      C_MUL:    w_op = OP_MUL;
      C_MULH:   w_op = OP_MULH;
      C_MULHSU: begin w_op = OP_MULHSU; w_sgn2 = 1'b0; end
      C_MULHU:  begin w_op = OP_MULHU;  w_sgn1 = 1'b0; w_sgn2 = 1'b0; end
      C_MULW:   w_op = OP_MULW;
      default:  begin w_valid = 1'b0; w_sgn1 = 1'b0; w_sgn2 = 1'b0; end
    endcase
  end

  // MULW operands are sign-extended from bit 31 so the shared magnitude path applies.
  assign w_a1   = (w_op == OP_MULW) ? {{(XLEN/2){bus.mult_op1[XLEN/2-1]}}, bus.mult_op1[XLEN/2-1:0]}
                                    : bus.mult_op1;
  assign w_a2   = (w_op == OP_MULW) ? {{(XLEN/2){bus.mult_op2[XLEN/2-1]}}, bus.mult_op2[XLEN/2-1:0]}
                                    : bus.mult_op2;
  assign w_neg1 = w_sgn1 & w_a1[XLEN-1];
  assign w_neg2 = w_sgn2 & w_a2[XLEN-1];
  assign w_mag1 = f_mag(w_a1, w_neg1);
  assign w_mag2 = f_mag(w_a2, w_neg2);
  assign w_last = (r_op == OP_MULW) ? LAST_W : LAST_D;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MUL;
      r_sign    <= 1'b0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_finish  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.mult_ready && w_valid) begin
            r_mcand  <= {{XLEN{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_acc    <= '0;
            r_sign   <= w_neg1 ^ w_neg2;
            r_op     <= w_op;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
            r_state  <= ((w_mag1 == '0) || (w_mag2 == '0)) ? S_DONE : S_CALC;
`else
            r_state  <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (r_mplier[0])
            r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == w_last)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_product <= f_select(r_op, f_neg(r_acc, r_sign));
          r_finish  <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.product_val = r_product;
  assign bus.mult_finish = r_finish;
  assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_rv64_multiplier.sv
// Self-checking bench for rv64_multiplier: directed vector table, corner sequences, random ops vs a 130-bit arithmetic model.
module tb_rv64_multiplier;

  localparam logic [9:0] C_MUL    = 10'b0110011_000;
  localparam logic [9:0] C_MULH   = 10'b0110011_001;
  localparam logic [9:0] C_MULHSU = 10'b0110011_010;
  localparam logic [9:0] C_MULHU  = 10'b0110011_011;
  localparam logic [9:0] C_MULW   = 10'b0111011_000;
  localparam logic [9:0] C_DIV    = 10'b0110011_100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rv64_multiplier_if bus ();
  rv64_multiplier dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  code;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on widened operands.
  function automatic logic [63:0] model(input logic [9:0] code, input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sb, p;
    sa = {{66{a[63]}}, a};
    sb = {{66{b[63]}}, b};
    case (code)
      C_MULHSU: sb = {66'b0, b};
      C_MULHU:  begin sa = {66'b0, a}; sb = {66'b0, b}; end
      C_MULW:   begin sa = {{98{a[31]}}, a[31:0]}; sb = {{98{b[31]}}, b[31:0]}; end
      default:  ;
    endcase
    p = sa * sb;
    case (code)
      C_MUL:   return p[63:0];
      C_MULW:  return {{32{p[31]}}, p[31:0]};
      default: return p[127:64];
    endcase
  endfunction

  function automatic int model_lat(input logic [9:0] code, input logic [63:0] a, input logic [63:0] b);
    logic zero;
    zero = (code == C_MULW) ? (a[31:0] == 32'd0 || b[31:0] == 32'd0) : (a == 64'd0 || b == 64'd0);
`ifdef MULT_ZERO_BYPASS_EN
    if (zero) return 1;
`else
    if (zero) return (code == C_MULW) ? 33 : 65;
`endif
    return (code == C_MULW) ? 33 : 65;
  endfunction

  // Issue one op, scramble operands after accept, wait for finish and check value/latency/busy/pulse.
  task automatic run_op(input string name, input logic [9:0] code, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int   n;
    logic got;
    logic busy_ok;
    @(negedge clk);
    bus.mult_ready = 1'b1;
    bus.inst_op_f3 = code;
    bus.mult_op1   = a;
    bus.mult_op2   = b;
    @(posedge clk);
    #1;
    bus.mult_ready = 1'b0;
    bus.mult_op1   = {$urandom, $urandom};
    bus.mult_op2   = {$urandom, $urandom};
    chk({name, " busy@E0"}, 64'(bus.busy_o), 64'd1);
    n = 0; got = 1'b0; busy_ok = 1'b1;
    while (n < 200 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.mult_finish) got = 1'b1;
      else if (!bus.busy_o) busy_ok = 1'b0;
    end
    chk({name, " finish seen"}, 64'(got), 64'd1);
    chk({name, " value"}, bus.product_val, exp);
    chk({name, " latency"}, 64'(n), 64'(exp_lat));
    chk({name, " busy held"}, 64'(busy_ok), 64'd1);
    chk({name, " busy@finish"}, 64'(bus.busy_o), 64'd0);
    @(posedge clk);
    #1;
    chk({name, " one-cycle pulse"}, 64'(bus.mult_finish), 64'd0);
    chk({name, " value held"}, bus.product_val, exp);
  endtask

  initial begin
    logic [63:0] ra, rb, prev;
    logic [9:0]  rc;
    logic        ok;
    int          n;
    logic [9:0]  codes[5];

    codes[0] = C_MUL; codes[1] = C_MULH; codes[2] = C_MULHSU; codes[3] = C_MULHU; codes[4] = C_MULW;

    tbl[0] = '{C_MUL,    64'd5, -64'sd5, 64'hFFFF_FFFF_FFFF_FFE7, 65};
    tbl[1] = '{C_MULH,   64'd5, -64'sd5, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    tbl[2] = '{C_MULHSU, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0000_0000_0000_0004, 65};
    tbl[3] = '{C_MULHU,  64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF6, 65};
    tbl[4] = '{C_MULW,   64'd5, 64'hFFFF_0000_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFE7, 33};
    tbl[5] = '{C_MULW,   64'hFFFF_FFFF_FFFF_FFFB, 64'h0000_FFFF_FFFF_FFFB, 64'h0000_0000_0000_0019, 33};
    tbl[6] = '{C_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65};
    tbl[7] = '{C_MUL,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65};
    tbl[8] = '{C_MUL,    64'd0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0};
    tbl[9] = '{C_MULW,   64'hFFFF_FFFF_0000_0000, 64'd7, 64'd0, 0};
    tbl[8].lat = model_lat(tbl[8].code, tbl[8].a, tbl[8].b);
    tbl[9].lat = model_lat(tbl[9].code, tbl[9].a, tbl[9].b);

    bus.mult_ready = 1'b0;
    bus.inst_op_f3 = '0;
    bus.mult_op1   = '0;
    bus.mult_op2   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset product_val", bus.product_val, 64'd0);
    chk("reset finish", 64'(bus.mult_finish), 64'd0);
    chk("reset busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].code, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    // Unsupported code must never be accepted.
    @(negedge clk);
    bus.mult_ready = 1'b1;
    bus.inst_op_f3 = C_DIV;
    bus.mult_op1   = 64'd3;
    bus.mult_op2   = 64'd4;
    ok = 1'b1;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.busy_o || bus.mult_finish) ok = 1'b0;
    end
    chk("invalid code ignored", 64'(ok), 64'd1);
    bus.mult_ready = 1'b0;

    // Back-to-back: ready held high, next op accepted on the edge after finish.
    @(negedge clk);
    bus.mult_ready = 1'b1;
    bus.inst_op_f3 = C_MULHU;
    bus.mult_op1   = 64'hDEAD_BEEF_0123_4567;
    bus.mult_op2   = 64'hFEDC_BA98_7654_3210;
    @(posedge clk);
    #1;
    n = 0;
    while (n < 200 && !bus.mult_finish) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b first value", bus.product_val, model(C_MULHU, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210));
    chk("b2b first latency", 64'(n), 64'd65);
    bus.inst_op_f3 = C_MUL;
    bus.mult_op1   = -64'sd123456789;
    bus.mult_op2   = 64'd987654321;
    @(posedge clk);
    #1;
    chk("b2b reaccept busy", 64'(bus.busy_o), 64'd1);
    bus.mult_ready = 1'b0;
    n = 0;
    while (n < 200 && !bus.mult_finish) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b second value", bus.product_val, model(C_MUL, -64'sd123456789, 64'd987654321));
    chk("b2b second latency", 64'(n), 64'd65);

    // Asynchronous reset in the middle of CALC aborts without a finish pulse.
    prev = bus.product_val;
    chk("pre-reset value nonzero", 64'(prev != 64'd0), 64'd1);
    @(negedge clk);
    bus.mult_ready = 1'b1;
    bus.inst_op_f3 = C_MUL;
    bus.mult_op1   = 64'd11;
    bus.mult_op2   = 64'd13;
    @(posedge clk);
    #1;
    bus.mult_ready = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midreset product_val", bus.product_val, 64'd0);
    chk("midreset finish", 64'(bus.mult_finish), 64'd0);
    chk("midreset busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ok = 1'b1;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.busy_o || bus.mult_finish) ok = 1'b0;
    end
    chk("no finish after abort", 64'(ok), 64'd1);

    // Random ops against the arithmetic model.
    for (int i = 0; i < 50; i++) begin
      rc = codes[$urandom_range(0, 4)];
      case ($urandom_range(0, 7))
        0:       ra = 64'h8000_0000_0000_0000;
        1:       ra = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       ra = {32'h0, $urandom} | 64'h1;
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 64'h8000_0000_0000_0000;
        1:       rb = 64'h0000_0000_8000_0000;
        2:       rb = 64'd1;
        default: rb = {$urandom, $urandom};
      endcase
      run_op($sformatf("rand%0d", i), rc, ra, rb, model(rc, ra, rb), model_lat(rc, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
